memx_update_sequencer: RTL

- Drives the x-vector update pass (x_new = x + alpha*p) of one solver iteration.
- Walks memX row by row and presents each x row plus the matching p row to an external fixed-latency vector multiply-add array (no_of_units lanes).
- Writes every returned result row back into memX at the same row address.
- Sits directly upstream of memX's write port and consumes its combinational read port; the vector arithmetic is outside this block.

---
 rtl/memx_update_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/memx_update_sequencer.sv
// memx_update_sequencer
//   Drives the x-vector update pass (x_new = x + alpha*p) of one solver iteration.
//   Walks memX row by row and issues each x row plus the matching p row to an
//   external fixed-latency vector multiply-add unit. Each returned result row is
//   written back into memX at the row address it was read from.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle pulse, begins a pass when idle
//   num_rows            rows to process (sampled on accepted start)
//   base_address        first memX row (sampled on accepted start)
//   read_address        memX read row address (combinational from registers)
//   x_row, p_row        x and p rows at read_address, same cycle
//   op_valid/op_x/op_p  registered operands to the vector unit
//   result_data         vector unit result, valid unit_latency cycles after op_valid
//   write_enable/write_address/write_data   registered memX write port
//   busy                high from an accepted start until done
//   done                one-cycle pulse once the final write has been issued
module memx_update_sequencer #(
   parameter int no_of_units   = 8,
   parameter int element_width = 32,
   parameter int address_width = 20,
   parameter int unit_latency  = 4
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [address_width-1:0]               num_rows,
   input  logic [address_width-1:0]               base_address,
   output logic [address_width-1:0]               read_address,
   input  logic [no_of_units*element_width-1:0]   x_row,
   input  logic [no_of_units*element_width-1:0]   p_row,
   output logic                                   op_valid,
   output logic [no_of_units*element_width-1:0]   op_x,
   output logic [no_of_units*element_width-1:0]   op_p,
   input  logic [no_of_units*element_width-1:0]   result_data,
   output logic                                   write_enable,
   output logic [address_width-1:0]              write_address,
   output logic [no_of_units*element_width-1:0]   write_data,
   output logic                                   busy,
   output logic                                   done
);

   localparam int AW = address_width;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

   state_t          state, state_next;
   logic [AW-1:0]   rows_q;
   logic [AW-1:0]   base_q;
   logic [AW-1:0]   issue_cnt;
   logic [AW-1:0]   write_cnt;
   logic            accept;
   logic            issuing;

   // Tag pipeline: stage 0 lines up with op_valid, the last stage with result_data.
   logic [unit_latency:0] tag_valid;
   logic [AW-1:0]         tag_addr [unit_latency+1];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next   = state;
      accept       = 1'b0;
      issuing      = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      read_address = '0;
      case (state)
         IDLE: begin
            if (start) begin
               if (num_rows != '0) begin
                  accept     = 1'b1;
                  state_next = ISSUE;
               end else begin
                  // Empty pass: no memX traffic, just the done pulse.
                  state_next = FINISH;
               end
            end
         end
         ISSUE: begin
            busy         = 1'b1;
            issuing      = 1'b1;
            read_address = base_q + issue_cnt;   // wraps modulo 2^address_width
            if (issue_cnt == rows_q - AW'(1)) state_next = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (write_cnt == rows_q) state_next = FINISH;
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rows_q        <= '0;
         base_q        <= '0;
         issue_cnt     <= '0;
         write_cnt     <= '0;
         op_valid      <= 1'b0;
         op_x          <= '0;
         op_p          <= '0;
         tag_valid     <= '0;
         for (int unsigned i = 0; i <= unit_latency; i++) tag_addr[i] <= '0;
         write_enable  <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
      end else begin
         if (accept) begin
            rows_q    <= num_rows;
            base_q    <= base_address;
            issue_cnt <= '0;
         end else if (issuing) begin
            issue_cnt <= issue_cnt + AW'(1);
         end

         op_valid <= issuing;
         if (issuing) begin
            op_x <= x_row;
            op_p <= p_row;
         end

         tag_valid   <= {tag_valid[unit_latency-1:0], issuing};
         tag_addr[0] <= read_address;
         for (int unsigned i = 1; i <= unit_latency; i++) tag_addr[i] <= tag_addr[i-1];

         write_enable <= tag_valid[unit_latency];
         if (tag_valid[unit_latency]) begin
            write_address <= tag_addr[unit_latency];
            write_data    <= result_data;
         end

         if (accept)                       write_cnt <= '0;
         else if (tag_valid[unit_latency]) write_cnt <= write_cnt + AW'(1);
      end
   end

endmodule
